// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file widths and writeback entry type
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-producer result FIFO with head, occupancy and pending-register mask
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [ADDR_W-1:0]   push_addr,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic [ADDR_W-1:0]   head_addr,
    output logic [DATA_W-1:0]   head_data,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic [NUM_REGS-1:0] pend
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: push_addr, data: push_data};
    end

    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Only slots between rd_ptr and rd_ptr+count hold live results.
    always_comb begin
        pend = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) < count)
                pend = pend | addr_onehot(mem[PTR_W'(rd_ptr + PTR_W'(j))].addr);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - dual write-port writeback arbiter in front of the register file
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic [ADDR_W-1:0]          wrport1_ctrl_add,
    output logic [DATA_W-1:0]          wrport1_data_in,
    output logic                       wrport1_wren,
    output logic [ADDR_W-1:0]          wrport2_ctrl_add,
    output logic [DATA_W-1:0]          wrport2_data_in,
    output logic                       wrport2_wren,
    output logic [NUM_REGS-1:0]        pend_mask,
    output logic                       idle
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]   head_addr  [NUM_SRC];
    logic [DATA_W-1:0]   head_data  [NUM_SRC];
    logic [CNT_W-1:0]    fifo_count [NUM_SRC];
    logic [NUM_REGS-1:0] fifo_pend  [NUM_SRC];
    logic [NUM_SRC-1:0]  fifo_full;
    logic [NUM_SRC-1:0]  fifo_empty;
    logic [NUM_SRC-1:0]  pop;

    logic [SRC_W-1:0] rr;
    logic [SRC_W-1:0] rr_next;
    logic [SRC_W-1:0] scan_idx;
    logic [SRC_W-1:0] last_idx;
    logic [SRC_W-1:0] g1_idx;
    logic [SRC_W-1:0] g2_idx;
    logic             g1_vld;
    logic             g2_vld;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // Ready comes from the registered full flag only, so a dequeue never frees a slot early.
        assign src_ready[i] = ~fifo_full[i];
        assign pop[i] = (g1_vld && g1_idx == SRC_W'(i)) || (g2_vld && g2_idx == SRC_W'(i));

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (src_valid[i] & src_ready[i]),
            .push_addr (src_addr[i*ADDR_W +: ADDR_W]),
            .push_data (src_data[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .head_addr (head_addr[i]),
            .head_data (head_data[i]),
            .count     (fifo_count[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .pend      (fifo_pend[i])
        );
    end

    // One circular scan from rr: first hit is g1, later hit with a different address is g2.
    always_comb begin
        g1_vld   = 1'b0;
        g2_vld   = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = SRC_W'((int'(rr) + k) % NUM_SRC);
            if (!g1_vld && !fifo_empty[scan_idx]) begin
                g1_vld = 1'b1;
                g1_idx = scan_idx;
            end else if (g1_vld && !g2_vld && !fifo_empty[scan_idx] &&
                         head_addr[scan_idx] != head_addr[g1_idx]) begin
                g2_vld = 1'b1;
                g2_idx = scan_idx;
            end
        end
        last_idx = g2_vld ? g2_idx : g1_idx;
        rr_next  = (last_idx == SRC_W'(NUM_SRC - 1)) ? '0 : last_idx + SRC_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr               <= '0;
            wrport1_wren     <= 1'b0;
            wrport1_ctrl_add <= '0;
            wrport1_data_in  <= '0;
            wrport2_wren     <= 1'b0;
            wrport2_ctrl_add <= '0;
            wrport2_data_in  <= '0;
        end else begin
            wrport1_wren <= g1_vld;
            wrport2_wren <= g2_vld;
            if (g1_vld) begin
                rr               <= rr_next;
                wrport1_ctrl_add <= head_addr[g1_idx];
                wrport1_data_in  <= head_data[g1_idx];
            end
            if (g2_vld) begin
                wrport2_ctrl_add <= head_addr[g2_idx];
                wrport2_data_in  <= head_data[g2_idx];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        idle      = !wrport1_wren && !wrport2_wren;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_mask = pend_mask | fifo_pend[i];
            if (fifo_count[i] != '0) idle = 1'b0;
        end
        if (wrport1_wren) pend_mask = pend_mask | addr_onehot(wrport1_ctrl_add);
        if (wrport2_wren) pend_mask = pend_mask | addr_onehot(wrport2_ctrl_add);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback stage that sits directly upstream of the 16x32b 4-read/2-write register file and drives both of its write ports. It collects results from NUM_SRC producers (execution units) over a valid/ready handshake and buffers each producer in a small FIFO. Each cycle it grants up to two buffered results to the two write ports and never presents a same-address pair. It exports a per-register pending mask that issue logic uses for hazard checks.

Parameters:
NUM_SRC, 4, number of result producers (2..8)
ADDR_W, 4, register address width (16 registers)
DATA_W, 32, register data width
DEPTH, 2, entries per producer FIFO (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
src_valid  input  NUM_SRC  producer i has a result
src_ready  output  NUM_SRC  producer i FIFO can accept
src_addr  input  NUM_SRC*ADDR_W  destination register, slice i
src_data  input  NUM_SRC*DATA_W  result data, slice i
wrport1_ctrl_add  output  ADDR_W  regfile write port 1 address
wrport1_data_in  output  DATA_W  regfile write port 1 data
wrport1_wren  output  1  regfile write port 1 enable
wrport2_ctrl_add  output  ADDR_W  regfile write port 2 address
wrport2_data_in  output  DATA_W  regfile write port 2 data
wrport2_wren  output  1  regfile write port 2 enable
pend_mask  output  2**ADDR_W  bit r set while any write to r is buffered or presented
idle  output  1  all FIFOs empty and both wren low

Behaviour:
- Reset (rst low, async):
  - Flush all FIFOs; rr pointer=0.
  - All wrport outputs=0; pend_mask=0; idle=1; src_ready=all 1.
  - In-flight results are discarded.
- Accept: enqueue on rising edge when src_valid[i] & src_ready[i].
  - src_ready[i] = count[i] < DEPTH, from registered state only. There is no combinational path from grant to ready.
  - A full FIFO deasserts ready even in a cycle where it dequeues.
- Grant (combinational from FIFO heads):
  - g1 = first non-empty source scanning from rr.
  - g2 = next non-empty source after g1, in circular order, whose head addr != g1 head addr.
  - If no such source exists, there is no g2 that cycle.
- Commit:
  - On the edge, dequeue the granted heads and register g1 onto wrport1 and g2 onto wrport2 (wren=1). Ungranted ports get wren=0.
  - Address and data hold their last value when wren=0.
  - rr <= (last granted index + 1) mod NUM_SRC. rr is unchanged when there is no grant.
- Latency:
  - Result accepted at edge N appears on wrport at edge N+1 at the earliest.
  - The regfile commits at edge N+2 and the value is readable after N+2.
- Same address: both ports never carry equal addresses with both wren=1. The regfile's port-1 priority is therefore never exercised.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order to the same register is by grant order only. Issue logic must use pend_mask to avoid two in-flight writes to one register from different sources.
- pend_mask[r] = OR over all valid FIFO entries with addr r, plus OR over registered wrport outputs (wren=1, add=r).
- idle = all counts 0 & !wrport1_wren & !wrport2_wren.
- Throughput: at most 2 writes/cycle. A single-source stream sustains 1/cycle with DEPTH>=2.

Decomposition:
- Package regfile_pkg holds ADDR_W, DATA_W, NUM_REGS = 2**ADDR_W, and an entry struct {addr, data}. The regfile and this block share it.
- One sub-module, wb_fifo: DEPTH-entry FIFO with count, full, empty and head outputs. It is instantiated NUM_SRC times.
- The arbiter and output registers live in the top level.

Test Plan:
1. Reset:
   - Hold rst low 2 cycles with src_valid=1111.
   - Required: src_ready=1111, wren both 0, pend_mask=0, idle=1, and nothing is enqueued.
2. Single write:
   - src0 addr 3 data 0x30 accepted at edge N.
   - Required: wrport1 add=3 data=0x30 wren=1 after N+1, with wrport2_wren=0.
   - pend_mask[3]=1 from after N through N+1 and clear after N+2.
   - Regfile read of R3 returns 0x30.
3. Dual grant:
   - src0 (addr 2, 0x20) and src1 (addr 9, 0x90) accepted at the same edge, rr=0.
   - Required: in the same cycle, port1 carries 2/0x20 and port2 carries 9/0x90.
   - Both registers read back correctly.
4. Address conflict:
   - src0 (addr 10, 100) and src1 (addr 10, 1000) accepted at the same edge, rr=0.
   - Required: cycle 1 has port1 = 10/100 and wrport2_wren=0.
   - Cycle 2 has port1 = 10/1000.
   - R10 finally reads 1000, and the two ports are never equal with both enabled.
5. Saturation and fairness:
   - All 4 sources are valid every cycle for 20 cycles, with addr = source index and data = sequence number.
   - Required: grants alternate (0,1),(2,3). src_ready drops once FIFOs fill.
   - Every accepted result is written exactly once, in per-source order, with no loss or duplication.
6. Reset mid-operation:
   - With all FIFOs full, drop rst asynchronously between clock edges.
   - Required: wren both 0, pend_mask=0 and idle=1 immediately.
   - After release, no stale write is presented.
